logic_gate_lab: RTL and testbench

LOGIC_GATE_LAB -- requirements
Module: logic_gate_lab

---
 rtl/logic_gate_lab.sv | 129 ++++++++++++
 tb/tb_logic_gate_lab.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/logic_gate_lab.sv
// Debounced N-switch gate lab: AND/OR/XOR (+inverses) LEDs; BTN steps MODE 0..4 to route one gate onto LED_SEL.
// Latency DB_CYCLES+2 edges from input sample to LEDs; no flow control (free-running, inputs always accepted).
module logic_gate_lab #(
    parameter int N         = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [N-1:0] SW,
    input  logic         BTN,
    output logic         LED_AND,
    output logic         LED_NAND,
    output logic         LED_OR,
    output logic         LED_NOR,
    output logic         LED_XOR,
    output logic         LED_SEL,
    output logic [2:0]   MODE
);
    localparam int            CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    // Bit N carries BTN so it shares the synchronizer/debouncer path with the switches.
    logic [N:0] raw;
    logic [N:0] s1;
    logic [N:0] s2;
    logic [N:0] stable;

    assign raw = {BTN, SW};

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    for (genvar gi = 0; gi <= N; gi++) begin : g_db
        logic [CW-1:0] cnt;
        logic          stab_q;

        always_ff @(posedge CLK) begin
            if (RST) begin
                cnt    <= '0;
                stab_q <= 1'b0;
            end else if (s2[gi] == stab_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stab_q <= s2[gi];
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable[gi] = stab_q;
    end

    logic       btn_prev;
    logic       btn_rise;
    logic [2:0] mode_q;
    logic [2:0] mode_nxt;
    logic       and_nxt;
    logic       or_nxt;
    logic       xor_nxt;
    logic       sel_nxt;

    assign btn_rise = stable[N] & ~btn_prev;

    // Mode state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q   <= 3'd0;
            btn_prev <= 1'b0;
        end else begin
            mode_q   <= mode_nxt;
            btn_prev <= stable[N];
        end
    end

    // Illegal codes 5..7 recover to 0 without waiting for a press.
    always_comb begin
        mode_nxt = mode_q;
        if (mode_q > 3'd4) begin
            mode_nxt = 3'd0;
        end else if (btn_rise) begin
            mode_nxt = (mode_q == 3'd4) ? 3'd0 : mode_q + 3'd1;
        end
    end

    // Selector uses next-cycle gate values and mode so LED_SEL always agrees with what is displayed.
    always_comb begin
        and_nxt = &stable[N-1:0];
        or_nxt  = |stable[N-1:0];
        xor_nxt = ^stable[N-1:0];
        sel_nxt = 1'b0;
        case (mode_nxt)
            3'd0:    sel_nxt = and_nxt;
            3'd1:    sel_nxt = or_nxt;
            3'd2:    sel_nxt = ~and_nxt;
            3'd3:    sel_nxt = ~or_nxt;
            3'd4:    sel_nxt = xor_nxt;
            default: sel_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            LED_AND  <= 1'b0;
            LED_NAND <= 1'b1;
            LED_OR   <= 1'b0;
            LED_NOR  <= 1'b1;
            LED_XOR  <= 1'b0;
            LED_SEL  <= 1'b0;
        end else begin
            LED_AND  <= and_nxt;
            LED_NAND <= ~and_nxt;
            LED_OR   <= or_nxt;
            LED_NOR  <= ~or_nxt;
            LED_XOR  <= xor_nxt;
            LED_SEL  <= sel_nxt;
        end
    end

    assign MODE = mode_q;

endmodule

// File: tb/tb_logic_gate_lab.sv
// Bench for logic_gate_lab (N=4, DB_CYCLES=4): directed latency/glitch/mode/reset cases plus random stimulus vs a reference model.
module tb_logic_gate_lab;
    localparam int N  = 4;
    localparam int DB = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] SW;
    logic       BTN;
    logic       LED_AND, LED_NAND, LED_OR, LED_NOR, LED_XOR, LED_SEL;
    logic [2:0] MODE;

    logic       n2_and, n2_nand, n2_or, n2_nor, n2_xor, n2_sel;
    logic [2:0] n2_mode;

    always #5 CLK = ~CLK;

    logic_gate_lab #(.N(N), .DB_CYCLES(DB)) dut (
        .CLK(CLK), .RST(RST), .SW(SW), .BTN(BTN),
        .LED_AND(LED_AND), .LED_NAND(LED_NAND), .LED_OR(LED_OR), .LED_NOR(LED_NOR),
        .LED_XOR(LED_XOR), .LED_SEL(LED_SEL), .MODE(MODE)
    );

    logic_gate_lab #(.N(2), .DB_CYCLES(2)) dut_n2 (
        .CLK(CLK), .RST(RST), .SW(SW[1:0]), .BTN(BTN),
        .LED_AND(n2_and), .LED_NAND(n2_nand), .LED_OR(n2_or), .LED_NOR(n2_nor),
        .LED_XOR(n2_xor), .LED_SEL(n2_sel), .MODE(n2_mode)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: raw samples queued, seen two edges late; a bit flips after DB consecutive differing edges.
    logic [4:0] hist[$];
    logic [4:0] m_stab;
    int         m_run[5];
    logic       m_prev;
    int         m_mode;
    logic       m_and, m_nand, m_or, m_nor, m_xor, m_sel;

    task automatic model_edge(input logic r, input logic [4:0] raw);
        logic [4:0] seen;
        logic [4:0] old;
        if (r) begin
            hist   = '{5'd0, 5'd0, 5'd0};
            m_stab = '0;
            for (int i = 0; i < 5; i++) m_run[i] = 0;
            m_prev = 1'b0;
            m_mode = 0;
            m_and  = 1'b0; m_or = 1'b0; m_xor = 1'b0;
            m_nand = 1'b1; m_nor = 1'b1; m_sel = 1'b0;
        end else begin
            hist.push_back(raw);
            seen = hist[1];
            void'(hist.pop_front());
            old    = m_stab;
            m_and  = &old[3:0];
            m_or   = |old[3:0];
            m_xor  = ^old[3:0];
            m_nand = !m_and;
            m_nor  = !m_or;
            if (old[4] && !m_prev) m_mode = (m_mode + 1) % 5;
            m_prev = old[4];
            case (m_mode)
                0:       m_sel = m_and;
                1:       m_sel = m_or;
                2:       m_sel = m_nand;
                3:       m_sel = m_nor;
                default: m_sel = m_xor;
            endcase
            for (int i = 0; i < 5; i++) begin
                if (seen[i] != m_stab[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DB) begin
                        m_stab[i] = seen[i];
                        m_run[i]  = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic r, input logic [3:0] sw, input logic b);
        RST = r;
        SW  = sw;
        BTN = b;
        @(posedge CLK);
        model_edge(r, {b, sw});
        @(negedge CLK);
        chk("model", 32'({MODE, LED_SEL, LED_XOR, LED_NOR, LED_OR, LED_NAND, LED_AND}),
            32'({3'(m_mode), m_sel, m_xor, m_nor, m_or, m_nand, m_and}));
        chk("n2_truth", 32'({n2_xor, n2_nand, n2_nor}),
            32'({n2_nand & n2_or, ~n2_and, ~n2_or}));
        chk("n2_mode_range", 32'(n2_mode <= 3'd4), 32'd1);
    endtask

    logic sel_tab[5];

    initial begin
        RST = 1'b1; SW = 4'd0; BTN = 1'b0;
        repeat (3) cyc(1'b1, 4'd0, 1'b0);
        chk("rst_leds", 32'({LED_AND, LED_NAND, LED_OR, LED_NOR, LED_XOR, LED_SEL}), 32'b010100);
        chk("rst_mode", 32'(MODE), 32'd0);

        repeat (10) cyc(1'b0, 4'd0, 1'b0);
        chk("idle_leds", 32'({LED_AND, LED_NAND, LED_OR, LED_NOR, LED_XOR, LED_SEL}), 32'b010100);

        // SW -> 1111 first sampled at edge t0 (i=0); LEDs move at t0+6
        for (int i = 0; i <= 6; i++) begin
            cyc(1'b0, 4'hF, 1'b0);
            chk("lat_leds", 32'({LED_AND, LED_NAND, LED_OR, LED_NOR, LED_XOR, LED_SEL}),
                (i == 6) ? 32'b101001 : 32'b010100);
        end

        repeat (12) cyc(1'b0, 4'b0111, 1'b0);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, (i < 3) ? 4'b1111 : 4'b0111, 1'b0);
            chk("glitch", 32'({LED_AND, LED_XOR, LED_OR}), 32'b011);
        end

        sel_tab = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int k = 1; k <= 5; k++) begin
            repeat (20) cyc(1'b0, 4'b0111, 1'b1);
            repeat (20) cyc(1'b0, 4'b0111, 1'b0);
            chk("btn_mode", 32'(MODE), 32'(k % 5));
            chk("btn_sel", 32'(LED_SEL), 32'(sel_tab[k % 5]));
        end
        repeat (100) cyc(1'b0, 4'b0111, 1'b1);
        repeat (20) cyc(1'b0, 4'b0111, 1'b0);
        chk("btn_hold_one_step", 32'(MODE), 32'd1);

        repeat (12) cyc(1'b0, 4'd0, 1'b0);
        repeat (4) cyc(1'b0, 4'b0001, 1'b0);
        cyc(1'b1, 4'b0001, 1'b0);
        chk("rst_mid_mode", 32'(MODE), 32'd0);
        for (int i = 0; i <= 6; i++) begin
            cyc(1'b0, 4'b0001, 1'b0);
            chk("rst_mid_or", 32'(LED_OR), 32'(i == 6));
        end

        repeat (12) cyc(1'b0, 4'd0, 1'b0);
        for (int i = 0; i <= 6; i++) begin
            cyc(1'b0, 4'b0001, 1'b1);
            chk("simul_xor", 32'(LED_XOR), 32'(i == 6));
            chk("simul_mode", 32'(MODE), 32'(i == 6));
        end
        repeat (20) cyc(1'b0, 4'b0001, 1'b1);
        repeat (20) cyc(1'b0, 4'b0001, 1'b0);
        chk("simul_mode_final", 32'(MODE), 32'd1);

        for (int n = 0; n < 300; n++) begin
            logic [3:0] rsw;
            logic       rb;
            logic       rr;
            int         len;
            rsw = 4'($urandom_range(0, 15));
            rb  = 1'($urandom_range(0, 1));
            rr  = ($urandom_range(0, 40) == 0);
            len = $urandom_range(1, 8);
            for (int j = 0; j < len; j++) cyc(rr && (j == 0), rsw, rb);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
